i2s_tx_stream: RTL

// Streaming I2S/left-justified stereo transmitter.
// - A ready/valid sample interface feeds a stereo-pair FIFO.
// - The block generates sclk/ws from mclk and serialises one L/R pair per frame, MSB first.
// - It sits between the DSP/mixer output and the external DAC pins.
// - It adds configurable slot width, format, enable/idle control and underrun reporting.
//

---
 rtl/i2s_tx_stream.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/i2s_tx_stream.sv
// rtl/i2s_tx_stream.sv - I2S / left-justified stereo transmitter fed by a stereo-pair FIFO
module i2s_tx_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32,
    parameter int MCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FORMAT     = 0
) (
    input  logic                                mclk,
    input  logic                                rst,
    input  logic                                en,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [DATA_WIDTH-1:0]               s_data_l,
    input  logic [DATA_WIDTH-1:0]               s_data_r,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic                                underrun,
    output logic                                sd_tx,
    output logic                                sclk,
    output logic                                ws
);
    localparam int FRAME = 2 * SLOT_WIDTH;
    localparam int BW    = $clog2(FRAME);
    localparam int DVW   = $clog2(MCLK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = $clog2(FIFO_DEPTH + 1);
    localparam int OFF   = (FORMAT == 0) ? 1 : 0;

    localparam logic [BW-1:0]  LAST_BIT = BW'(FRAME - 1);
    localparam logic [BW-1:0]  SLOT     = BW'(SLOT_WIDTH);
    localparam logic [DVW-1:0] DIV_HALF = DVW'(MCLK_DIV / 2 - 1);
    localparam logic [DVW-1:0] DIV_LAST = DVW'(MCLK_DIV - 1);
    localparam logic [LW-1:0]  LVL_FULL = LW'(FIFO_DEPTH);

    if (DATA_WIDTH < 2 || DATA_WIDTH > SLOT_WIDTH - 1 || MCLK_DIV < 4 || (MCLK_DIV % 2) != 0 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || (FORMAT != 0 && FORMAT != 1))
    begin : g_bad_params
        $error("i2s_tx_stream: illegal parameter set");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [DVW-1:0]        div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  sclk_q, sclk_d;
    logic                  ws_q, ws_d;
    logic                  sd_q, sd_d;
    logic                  under_q, under_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic [AW-1:0]         wr_q, wr_d;
    logic [AW-1:0]         rd_q, rd_d;
    logic [LW-1:0]         cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic                  push, pop, empty;
    logic [BW-1:0]         slot_pos;
    int                    data_idx;
    logic [DATA_WIDTH-1:0] sample, bit_mask;

    assign s_ready    = (cnt_q != LVL_FULL);
    assign empty      = (cnt_q == '0);
    assign push       = s_valid && s_ready;
    assign fifo_level = cnt_q;
    assign underrun   = under_q;
    assign sd_tx      = sd_q;
    assign sclk       = sclk_q;
    assign ws         = ws_q;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        ws_d     = ws_q;
        sd_d     = sd_q;
        under_d  = 1'b0;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        pop      = 1'b0;
        slot_pos = '0;
        data_idx = 0;
        sample   = '0;
        bit_mask = '0;
        case (state_q)
            IDLE: begin
                div_d  = '0;
                bit_d  = LAST_BIT;
                sclk_d = 1'b0;
                ws_d   = 1'b0;
                sd_d   = 1'b0;
                if (en) state_d = RUN;
            end
            default: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_HALF) sclk_d = 1'b1;
                if (div_q == DIV_LAST) begin
                    sclk_d = 1'b0;
                    div_d  = '0;
                    if (bit_q == LAST_BIT && !en) begin
                        state_d = IDLE;
                        ws_d    = 1'b0;
                        sd_d    = 1'b0;
                    end else begin
                        if (bit_q == LAST_BIT) begin
                            bit_d = '0;
                            // An empty FIFO at frame start plays silence rather than stale data
                            if (empty) begin
                                hold_l_d = '0;
                                hold_r_d = '0;
                                under_d  = 1'b1;
                            end else begin
                                hold_l_d = mem_l[rd_q];
                                hold_r_d = mem_r[rd_q];
                                pop      = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                        ws_d     = (bit_d >= SLOT);
                        slot_pos = ws_d ? (bit_d - SLOT) : bit_d;
                        data_idx = int'(slot_pos) - OFF;
                        sample   = ws_d ? hold_r_d : hold_l_d;
                        bit_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (DATA_WIDTH - 1 - data_idx);
                        sd_d     = (data_idx >= 0 && data_idx < DATA_WIDTH) ? |(sample & bit_mask) : 1'b0;
                    end
                end
            end
        endcase

        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= LAST_BIT;
            sclk_q   <= 1'b0;
            ws_q     <= 1'b0;
            sd_q     <= 1'b0;
            under_q  <= 1'b0;
            hold_l_q <= '0;
            hold_r_q <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            ws_q     <= ws_d;
            sd_q     <= sd_d;
            under_q  <= under_d;
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge mclk) begin
        if (push) begin
            mem_l[wr_q] <= s_data_l;
            mem_r[wr_q] <= s_data_r;
        end
    end
endmodule
